// File: rtl/fetch_unit.sv
// Instruction fetch/sequencing stage: loadable instruction memory, PC, and registered instruction fields.
module fetch_unit #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PC_W  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_en,
  input  logic [PC_W-1:0] load_addr,
  input  logic [15:0]     load_data,
  input  logic            start,
  input  logic            stall,
  input  logic            branch,
  input  logic            zero,
  output logic [3:0]      opcode,
  output logic [3:0]      rd,
  output logic [3:0]      rs,
  output logic [3:0]      imm,
  output logic [PC_W-1:0] pc,
  output logic            instr_valid,
  output logic            halted,
  output logic [15:0]     instr_count
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t          state_q, state_d;
  logic [15:0]     mem [DEPTH];
  logic [PC_W-1:0] pc_q, pc_d, pc_next, imm_ext;
  logic [15:0]     ir_q, ir_d;
  logic            valid_q, valid_d;
  logic            halted_q, halted_d;
  logic [15:0]     count_q, count_d;
  logic            mem_we;
  logic            go_run;

  // Sign-extend the 4-bit immediate to PC width, or truncate when the PC is narrower.
  if (PC_W > 4) begin : g_imm_wide
    assign imm_ext = {{(PC_W-4){ir_q[3]}}, ir_q[3:0]};
  end else begin : g_imm_narrow
    assign imm_ext = ir_q[PC_W-1:0];
  end

  always_comb begin
    pc_next = (branch & zero) ? pc_q + imm_ext : pc_q + PC_W'(1);
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    count_d  = count_q;
    mem_we   = 1'b0;
    go_run   = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_en) begin
          mem_we = 1'b1;
        end else if (start) begin
          go_run = 1'b1;
        end
      end
      RUN: begin
        if (!stall) begin
          count_d = count_q + 16'd1;
          if (ir_q[15:12] == 4'hF) begin
            state_d  = HALT;
            valid_d  = 1'b0;
            halted_d = 1'b1;
          end else begin
            pc_d = pc_next;
            ir_d = mem[pc_next];
          end
        end
      end
      HALT: begin
        go_run = start;
      end
      default: state_d = IDLE;
    endcase

    if (go_run) begin
      state_d  = RUN;
      pc_d     = '0;
      ir_d     = mem[0];
      valid_d  = 1'b1;
      halted_d = 1'b0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      count_q  <= count_d;
    end
  end

  assign opcode      = ir_q[15:12];
  assign rd          = ir_q[11:8];
  assign rs          = ir_q[7:4];
  assign imm         = ir_q[3:0];
  assign pc          = pc_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: per-cycle expectations from a behavioural model, checked by a separate monitor.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [15:0] load_data;
  logic        start;
  logic        stall;
  logic        branch;
  logic        zero;
  logic [3:0]  opcode;
  logic [3:0]  rd;
  logic [3:0]  rs;
  logic [3:0]  imm;
  logic [3:0]  pc;
  logic        instr_valid;
  logic        halted;
  logic [15:0] instr_count;

  fetch_unit #(.DEPTH(16), .PC_W(4)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .stall(stall), .branch(branch),
    .zero(zero), .opcode(opcode), .rd(rd), .rs(rs), .imm(imm), .pc(pc),
    .instr_valid(instr_valid), .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  pc;
    logic [15:0] ir;
    logic        valid;
    logic        halted;
    logic [15:0] count;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  string phase = "reset";
  int    n_tests = 0;
  int    n_fail  = 0;

  // Behavioural reference model
  logic [15:0] mem_m [16];
  bit          m_run;
  bit          m_halt;
  int          m_pc;
  logic [15:0] m_ir;
  int          m_count;

  function automatic obs_t model_obs();
    obs_t o;
    o.pc     = 4'(m_pc);
    o.ir     = m_ir;
    o.valid  = m_run;
    o.halted = m_halt;
    o.count  = 16'(m_count);
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.pc     = pc;
    o.ir     = {opcode, rd, rs, imm};
    o.valid  = instr_valid;
    o.halted = halted;
    o.count  = instr_count;
    return o;
  endfunction

  task automatic check(string nm, obs_t got, obs_t want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got pc=%0d ir=%h valid=%b halted=%b count=%0d, expected pc=%0d ir=%h valid=%b halted=%b count=%0d",
               nm, got.pc, got.ir, got.valid, got.halted, got.count,
               want.pc, want.ir, want.valid, want.halted, want.count);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_halt = 1'b0; m_pc = 0; m_ir = '0; m_count = 0;
  endtask

  task automatic model_step(int le, int la, int ld, int st, int sl, int br, int z);
    int off;
    if (m_run) begin
      if (sl == 0) begin
        m_count = (m_count + 1) % 65536;
        if (m_ir[15:12] == 4'hF) begin
          m_run  = 1'b0;
          m_halt = 1'b1;
        end else begin
          off = int'(m_ir[3:0]);
          if (off > 7) off -= 16;
          if (br != 0 && z != 0) m_pc = (((m_pc + off) % 16) + 16) % 16;
          else                   m_pc = (m_pc + 1) % 16;
          m_ir = mem_m[m_pc];
        end
      end
    end else if (!m_halt && le != 0) begin
      mem_m[la % 16] = 16'(ld);
    end else if (st != 0) begin
      m_run = 1'b1; m_halt = 1'b0; m_pc = 0; m_ir = mem_m[0]; m_count = 0;
    end
  endtask

  // One clock cycle: called at a falling edge, returns at the next falling edge.
  task automatic cyc(int le, int la, int ld, int st, int sl, int br, int z);
    load_en   = (le != 0);
    load_addr = 4'(la);
    load_data = 16'(ld);
    start     = (st != 0);
    stall     = (sl != 0);
    branch    = (br != 0);
    zero      = (z != 0);
    model_step(le, la, ld, st, sl, br, z);
    @(posedge clk);
    exp_q.push_back(model_obs());
    name_q.push_back(phase);
    @(negedge clk);
  endtask

  task automatic run_n(int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_start();
    cyc(0, 0, 0, 1, 0, 0, 0);
  endtask

  // Assert reset between edges and check outputs before any clock edge.
  task automatic do_reset();
    load_en = 1'b0; start = 1'b0; stall = 1'b0; branch = 1'b0; zero = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check({phase, "_async_reset"}, dut_obs(), model_obs());
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : monitor
    obs_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check(nm, dut_obs(), e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [15:0] w;
    int          le, st;
    reset = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; stall = 1'b0; branch = 1'b0; zero = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    phase = "load_run";
    for (int i = 0; i < 16; i++) begin
      case (i)
        0:       w = 16'h1123;
        1:       w = 16'h2210;
        2:       w = 16'h3001;
        3:       w = 16'hF000;
        default: w = 16'h0000;
      endcase
      cyc(1, i, int'(w), 0, 0, 0, 0);
    end
    do_start();
    run_n(5);

    phase = "load_in_halt";
    cyc(1, 0, 16'hFFFF, 0, 0, 0, 0);

    phase = "stall";
    do_start();
    cyc(1, 1, 16'hF000, 0, 0, 0, 0);
    run_n(1);
    cyc(0, 0, 0, 0, 1, 1, 1);
    cyc(0, 0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 1, 1, 1);
    run_n(2);

    phase = "readback";
    do_start();
    run_n(5);
    do_reset();

    phase = "start_with_load";
    for (int i = 0; i < 15; i++) begin
      case (i)
        5:       w = 16'h100E;
        12:      w = 16'h1007;
        default: w = 16'h0000;
      endcase
      cyc(1, i, int'(w), 0, 0, 0, 0);
    end
    cyc(1, 15, 16'h0000, 1, 0, 0, 0);
    run_n(1);

    phase = "branch";
    do_start();
    run_n(5);
    cyc(0, 0, 0, 0, 0, 1, 1);
    run_n(2);
    cyc(0, 0, 0, 0, 0, 1, 0);
    run_n(1);

    phase = "reset_mid";
    do_reset();
    do_start();
    run_n(12);
    phase = "wrap";
    cyc(0, 0, 0, 0, 0, 1, 1);
    run_n(13);

    phase = "random";
    do_reset();
    for (int i = 0; i < 16; i++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 5) == 0) w[15:12] = 4'hF;
      cyc(1, i, int'(w), 0, 0, 0, 0);
    end
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        st = m_run ? 0 : int'($urandom_range(0, 2) == 0);
        le = (!m_run && !m_halt) ? int'($urandom_range(0, 3) == 0)
                                 : int'($urandom_range(0, 7) == 0);
        cyc(le, int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)), st,
            int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 1)));
      end
    end

    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
